// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-memory bus plus decode/execute control and the
// decode-side instruction outputs of the fetch stage, bundled as one interface.
interface fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        instr_valid;

    // Fetch unit side
    modport master (
        output imem_req, imem_addr, instr, pc, instr_valid,
        input  imem_rdata, stall, redirect, redirect_pc
    );

    // Memory / decode / execute side
    modport slave (
        input  imem_req, imem_addr, instr, pc, instr_valid,
        output imem_rdata, stall, redirect, redirect_pc
    );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: RV32I instruction fetch stage. Issues word reads to a synchronous
// instruction memory, buffers one response across a decode stall, squashes
// wrong-path fetches on redirect and presents NOP bubbles when nothing is valid.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input logic          clk,
    input logic          reset_n,
    fetch_unit_if.master bus
);
    typedef enum logic [1:0] {BOOT, RUN, STALL} state_t;

    state_t      state;
    logic [31:0] fetch_pc;
    logic        inflight;
    logic [31:0] inflight_pc;
    logic        hold_valid;
    logic [31:0] hold_instr;
    logic [31:0] hold_pc;
    logic [31:0] instr_q;
    logic [31:0] pc_q;
    logic        valid_q;

    logic        take_redirect;
    logic        issue;
    logic [31:0] redirect_target;

    // A redirect seen during the BOOT cycle is ignored entirely.
    assign take_redirect   = bus.redirect && (state != BOOT);
    assign issue           = (state != BOOT) && !bus.stall && !bus.redirect;
    assign redirect_target = bus.redirect_pc & ~32'd3;

    assign bus.imem_req    = issue;
    assign bus.imem_addr   = fetch_pc;
    assign bus.instr       = instr_q;
    assign bus.pc          = pc_q;
    assign bus.instr_valid = valid_q;

    // Control FSM: one BOOT cycle after reset, then RUN/STALL tracking decode stall.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= BOOT;
        end else begin
            case (state)
                BOOT:    state <= RUN;
                RUN:     state <= (bus.stall && !bus.redirect) ? STALL : RUN;
                STALL:   state <= (!bus.stall || bus.redirect) ? RUN : STALL;
                default: state <= BOOT;
            endcase
        end
    end

    // Request address, in-flight flag, hold-buffer occupancy and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_pc   <= RESET_PC;
            inflight   <= 1'b0;
            hold_valid <= 1'b0;
            instr_q    <= NOP_INSTR;
            pc_q       <= RESET_PC;
            valid_q    <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                fetch_pc <= fetch_pc + 32'd4;
            end
            if (take_redirect) begin
                // Restart at the target; any arriving or held word is wrong-path.
                fetch_pc   <= redirect_target;
                hold_valid <= 1'b0;
                instr_q    <= NOP_INSTR;
                valid_q    <= 1'b0;
            end else if (bus.stall) begin
                // Outputs frozen; at most one response can land while stalled.
                if (inflight) begin
                    hold_valid <= 1'b1;
                end
            end else if (hold_valid) begin
                instr_q    <= hold_instr;
                pc_q       <= hold_pc;
                valid_q    <= 1'b1;
                hold_valid <= 1'b0;
            end else if (inflight) begin
                instr_q <= bus.imem_rdata;
                pc_q    <= inflight_pc;
                valid_q <= 1'b1;
            end else begin
                instr_q <= NOP_INSTR;
                valid_q <= 1'b0;
            end
        end
    end

    // Payload registers; their contents only matter when the matching flag is set.
    always_ff @(posedge clk) begin
        if (issue) begin
            inflight_pc <= fetch_pc;
        end
        if (!take_redirect && bus.stall && inflight) begin
            hold_instr <= bus.imem_rdata;
            hold_pc    <= inflight_pc;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: table-driven per-cycle checks of the fetch stage against a
// synchronous memory returning 32'h00A0_0093 + addr, plus an async-reset sequence.
module tb_fetch_unit;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct {
        logic        stall;
        logic        redirect;
        logic [31:0] rpc;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
    } vec_t;

    logic clk = 1'b0;
    logic reset_n;
    int   tests  = 0;
    int   failed = 0;

    vec_t main_tbl[28];
    vec_t boot_tbl[6];

    fetch_unit_if bus ();

    fetch_unit #(
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (NOP)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h00A0_0093 + a;
    endfunction

    // Synchronous instruction memory: data one cycle after an accepted request.
    always @(posedge clk) begin
        if (bus.imem_req) bus.imem_rdata <= mem_word(bus.imem_addr);
        else              bus.imem_rdata <= 32'hBAD0_BAD0;
    end

    function automatic vec_t mk(input logic s, input logic r, input logic [31:0] rp,
                                input logic er, input logic [31:0] ea,
                                input logic ev, input logic [31:0] ep);
        vec_t v;
        v.stall = s; v.redirect = r; v.rpc = rp;
        v.exp_req = er; v.exp_addr = ea; v.exp_valid = ev; v.exp_pc = ep;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, " req"},   {31'd0, bus.imem_req}, 32'd0);
        check({tag, " addr"},  bus.imem_addr, 32'd0);
        check({tag, " valid"}, {31'd0, bus.instr_valid}, 32'd0);
        check({tag, " pc"},    bus.pc, 32'd0);
        check({tag, " instr"}, bus.instr, NOP);
    endtask

    // Drive one cycle's inputs (called just after a falling edge), check, advance.
    task automatic run_vec(input string tag, input int idx, input vec_t v);
        logic [31:0] exp_instr;
        bus.stall       = v.stall;
        bus.redirect    = v.redirect;
        bus.redirect_pc = v.rpc;
        #1;
        exp_instr = v.exp_valid ? mem_word(v.exp_pc) : NOP;
        check($sformatf("%s c%0d req", tag, idx),   {31'd0, bus.imem_req}, {31'd0, v.exp_req});
        check($sformatf("%s c%0d addr", tag, idx),  bus.imem_addr, v.exp_addr);
        check($sformatf("%s c%0d valid", tag, idx), {31'd0, bus.instr_valid}, {31'd0, v.exp_valid});
        check($sformatf("%s c%0d pc", tag, idx),    bus.pc, v.exp_pc);
        check($sformatf("%s c%0d instr", tag, idx), bus.instr, exp_instr);
        @(negedge clk);
    endtask

    initial begin
        //                    stall redir rpc            req addr           valid pc
        main_tbl[0]  = mk(1'b0, 1'b1, 32'h0000_0200, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000);
        main_tbl[1]  = mk(1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_0000, 1'b0, 32'h0000_0000);
        main_tbl[2]  = mk(1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_0004, 1'b0, 32'h0000_0000);
        main_tbl[3]  = mk(1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_0008, 1'b1, 32'h0000_0000);
        main_tbl[4]  = mk(1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_000C, 1'b1, 32'h0000_0004);
        main_tbl[5]  = mk(1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_0010, 1'b1, 32'h0000_0008);
        main_tbl[6]  = mk(1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_0014, 1'b1, 32'h0000_000C);
        main_tbl[7]  = mk(1'b1, 1'b0, 32'h0,         1'b0, 32'h0000_0018, 1'b1, 32'h0000_0010);
        main_tbl[8]  = mk(1'b1, 1'b0, 32'h0,         1'b0, 32'h0000_0018, 1'b1, 32'h0000_0010);
        main_tbl[9]  = mk(1'b1, 1'b0, 32'h0,         1'b0, 32'h0000_0018, 1'b1, 32'h0000_0010);
        main_tbl[10] = mk(1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_0018, 1'b1, 32'h0000_0010);
        main_tbl[11] = mk(1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_001C, 1'b1, 32'h0000_0014);
        main_tbl[12] = mk(1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_0020, 1'b1, 32'h0000_0018);
        main_tbl[13] = mk(1'b0, 1'b1, 32'h0000_0102, 1'b0, 32'h0000_0024, 1'b1, 32'h0000_001C);
        main_tbl[14] = mk(1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_0100, 1'b0, 32'h0000_001C);
        main_tbl[15] = mk(1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_0104, 1'b0, 32'h0000_001C);
        main_tbl[16] = mk(1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_0108, 1'b1, 32'h0000_0100);
        main_tbl[17] = mk(1'b1, 1'b0, 32'h0,         1'b0, 32'h0000_010C, 1'b1, 32'h0000_0104);
        main_tbl[18] = mk(1'b1, 1'b1, 32'h0000_0300, 1'b0, 32'h0000_010C, 1'b1, 32'h0000_0104);
        main_tbl[19] = mk(1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_0300, 1'b0, 32'h0000_0104);
        main_tbl[20] = mk(1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_0304, 1'b0, 32'h0000_0104);
        main_tbl[21] = mk(1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_0308, 1'b1, 32'h0000_0300);
        main_tbl[22] = mk(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0000_030C, 1'b1, 32'h0000_0304);
        main_tbl[23] = mk(1'b0, 1'b0, 32'h0,         1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0000_0304);
        main_tbl[24] = mk(1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_0000, 1'b0, 32'h0000_0304);
        main_tbl[25] = mk(1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_0004, 1'b1, 32'hFFFF_FFFC);
        main_tbl[26] = mk(1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_0008, 1'b1, 32'h0000_0000);
        main_tbl[27] = mk(1'b1, 1'b0, 32'h0,         1'b0, 32'h0000_000C, 1'b1, 32'h0000_0004);

        boot_tbl[0]  = mk(1'b0, 1'b0, 32'h0,         1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000);
        boot_tbl[1]  = mk(1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_0000, 1'b0, 32'h0000_0000);
        boot_tbl[2]  = mk(1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_0004, 1'b0, 32'h0000_0000);
        boot_tbl[3]  = mk(1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_0008, 1'b1, 32'h0000_0000);
        boot_tbl[4]  = mk(1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_000C, 1'b1, 32'h0000_0004);
        boot_tbl[5]  = mk(1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_0010, 1'b1, 32'h0000_0008);

        reset_n         = 1'b0;
        bus.stall       = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 32'h0;
        repeat (2) @(negedge clk);
        #1;
        check_reset("reset");

        // Release reset; the next rising edge is cycle 0 (BOOT).
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 28; i++) run_vec("main", i, main_tbl[i]);

        // Cycle 28: still stalled with the hold buffer full.
        bus.stall = 1'b1;
        #1;
        check("hold pc",    bus.pc, 32'h0000_0004);
        check("hold instr", bus.instr, mem_word(32'h0000_0004));
        check("hold req",   {31'd0, bus.imem_req}, 32'd0);

        // Asynchronous reset mid-stall: outputs must drop before any clock edge.
        #1;
        reset_n = 1'b0;
        #1;
        check_reset("async reset");

        @(negedge clk);
        @(negedge clk);
        bus.stall = 1'b0;
        reset_n   = 1'b1;
        for (int i = 0; i < 6; i++) run_vec("reboot", i, boot_tbl[i]);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage for the single-issue RV32I core: drives the program counter, issues word reads to a synchronous instruction memory, and presents `{instr, pc, instr_valid}` to `decode`. It honours a decode-side stall with a one-entry hold buffer and takes redirects (branch/jump targets) from execute. It squashes wrong-path fetches and injects NOPs (`ADDI x0,x0,0`) as bubbles.

## Interface
- `RESET_PC`, default `32'h0000_0000`: address of the first fetch after reset.
- `NOP_INSTR`, default `32'h0000_0013`: value driven on `instr` whenever `instr_valid` = 0.
- `clk`  in  1  single clock, rising edge.
- `reset_n`  in  1  reset, asynchronous and active-low.
- `imem_req`  out  1  read request this cycle.
- `imem_addr`  out  32  word address of the read; bits [1:0] are always 0.
- `imem_rdata`  in  32  read data, valid exactly one cycle after an accepted `imem_req`.
- `stall`  in  1  decode cannot accept; the output registers must hold.
- `redirect`  in  1  flush the pipeline and restart at `redirect_pc`.
- `redirect_pc`  in  32  redirect target; bits [1:0] are ignored and forced to 0.
- `instr`  out  32  instruction to decode.
- `pc`  out  32  address of `instr`.
- `instr_valid`  out  1  `instr`/`pc` carry a real fetched instruction.

## Operation
- Internal registers:
  - `fetch_pc`: next request address.
  - `inflight` plus `inflight_pc`: a response is due this cycle.
  - `hold_valid` plus `hold_instr` and `hold_pc`: the one-entry hold buffer.
  - Output registers.
  - FSM state.
- FSM states are BOOT, RUN and STALL.
  - BOOT is entered on reset. It lasts one cycle with no request, then goes to RUN.
  - RUN → STALL when `stall`=1 and `redirect`=0.
  - STALL → RUN when `stall`=0 or `redirect`=1.
  - `redirect` from any state except BOOT → RUN.
- Request rule: `imem_req` = (state != BOOT) and not `stall` and not `redirect`. `imem_addr` = `fetch_pc`.
  - On each issued request: `fetch_pc` += 4 (wraps modulo 2^32), `inflight` ← 1, `inflight_pc` ← `fetch_pc`.
  - Otherwise `inflight` ← 0.
- Output update when `stall`=0 and `redirect`=0:
  - If `hold_valid`: load the output from the hold buffer and clear `hold_valid`.
  - Else if `inflight`: load `{imem_rdata, inflight_pc, 1}`.
  - Else: load `{NOP_INSTR, pc, 0}`.
- Stall, no redirect:
  - Output registers are unchanged.
  - An arriving response (`inflight`=1) is written into the hold buffer.
  - Because requests stop while stalled, at most one response can arrive, so a single hold entry never overflows.
- Redirect has priority over stall and over everything else:
  - `fetch_pc` ← `{redirect_pc[31:2], 2'b00}`.
  - `hold_valid` ← 0 and `inflight` ← 0; the arriving response is discarded.
  - Output ← `{NOP_INSTR, pc, 0}`.
- Release from stall: in the same cycle `stall` falls, the held entry goes to the output and a new request is issued at `fetch_pc`. This keeps the stream gap-free.
- Reset values while `reset_n` is low:
  - `fetch_pc`=`RESET_PC`.
  - `instr`=`NOP_INSTR`, `pc`=`RESET_PC`, `instr_valid`=0.
  - `inflight`=0, `hold_valid`=0, state=BOOT.
  - `imem_req`=0; `imem_addr`=`RESET_PC`.
- Reset asserted mid-stall or mid-redirect: all state is dropped immediately (asynchronous), with no partial output.

## Timing
- Cycle 0 is the first rising edge with `reset_n`=1.
- BOOT spans cycle 0. The first request (`RESET_PC`) is issued in cycle 1, and `instr_valid`=1 with `pc`=`RESET_PC` from cycle 3.
- Fetch-to-decode latency is 2 cycles from request to valid output. Sustained throughput is one instruction per cycle with no bubbles when unstalled.
- Redirect asserted in cycle n:
  - Cycle n+1: request at the target.
  - Cycles n+1 and n+2: `instr_valid`=0.
  - Cycle n+3: target instruction valid.
- Stall asserted in cycle s:
  - Outputs are frozen from cycle s+1 onward.
  - The first instruction after release appears one cycle after `stall` falls, and no instruction is lost or duplicated.
- `redirect` and `stall` asserted in the same cycle behave as `redirect` alone.
- A redirect in the BOOT cycle is ignored.

## Test plan
- Reset release with a memory model returning `32'h00A0_0093 + addr`:
  - `imem_addr` must be 0, 4, 8, … from cycle 1.
  - `instr_valid` rises in cycle 3 with `pc`=0 and `instr`=`32'h00A0_0093`.
  - The run continues back-to-back with `pc` +4 per cycle.
- `stall` high for 3 cycles while streaming at `pc`=`0x10`:
  - Outputs hold `pc`=`0x10`.
  - `imem_req`=0 during the stall.
  - After release the sequence is `0x14`, `0x18`, … with no gap, duplicate or loss.
- `redirect` with `redirect_pc`=`32'h0000_0102`:
  - Next request at `0x100`.
  - Two `instr_valid`=0 cycles carrying `NOP_INSTR`.
  - Then `pc`=`0x100`.
  - The in-flight wrong-path word never reaches the output.
- `redirect` in the same cycle as `stall` with the hold buffer full:
  - The hold entry is discarded.
  - The next valid `pc` equals the target, 3 cycles later.
- Wrap-around: `redirect_pc`=`32'hFFFF_FFFC` leads to valid `pc` values `FFFF_FFFC` then `0000_0000`.
- Assert `reset_n`=0 mid-stall with the hold buffer full:
  - Outputs go to reset values immediately.
  - After release the stream restarts at `RESET_PC` with BOOT timing.
